// File: rtl/cfu_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfu_mac_pkg
// Purpose  : Shared definitions for the SIMD MAC custom-function unit.
//            Holds op codes, lane geometry, datapath widths and the
//            command FSM state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cfu_mac_pkg;

    // Lane geometry: four int8 lanes packed into a 32-bit operand
    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    // Datapath widths
    localparam int OFF_W  = 9;   // signed input / filter offset
    localparam int OPND_W = 10;  // offset-adjusted lane operand
    localparam int PROD_W = 20;  // lane product
    localparam int DOT_W  = 22;  // four-lane dot product

    // Operation codes carried in function_id[2:0]
    localparam logic [2:0] OP_MAC    = 3'd0;
    localparam logic [2:0] OP_SETOFF = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_READ   = 3'd3;
    localparam logic [2:0] OP_CLRALL = 3'd4;

    // Command FSM
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/simd_dot4.sv
`default_nettype none
// ============================================================================
// Module   : simd_dot4
// Purpose  : Four-lane int8 dot product with per-operand offsets.
//            Each lane adds the signed offsets, multiplies, and the four
//            products are summed by a two-level adder tree. With
//            PIPE_MUL=1 the lane products are registered on 'capture'.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            capture         - load product registers (PIPE_MUL=1 only)
//            in0, in1        - packed int8 activations / weights
//            in_off, flt_off - 9-bit signed offsets
//            dot             - 22-bit signed dot product
// Revision : 1.0 - initial release
// ============================================================================
module simd_dot4
    import cfu_mac_pkg::*;
#(
    parameter int PIPE_MUL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic [31:0]      in0,
    input  logic [31:0]      in1,
    input  logic [OFF_W-1:0] in_off,
    input  logic [OFF_W-1:0] flt_off,
    output logic [DOT_W-1:0] dot
);

    localparam int PAIR_W = DOT_W - 1;

    logic signed [PROD_W-1:0] prod     [LANES];
    logic signed [PROD_W-1:0] prod_use [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [OPND_W-1:0] a;
        logic signed [OPND_W-1:0] b;
        assign a = OPND_W'($signed(in0[LANE_W*i +: LANE_W])) + OPND_W'($signed(in_off));
        assign b = OPND_W'($signed(in1[LANE_W*i +: LANE_W])) + OPND_W'($signed(flt_off));
        assign prod[i] = PROD_W'(a) * PROD_W'(b);
    end

    if (PIPE_MUL != 0) begin : g_pipe
        logic signed [PROD_W-1:0] prod_q [LANES];
        logic signed [PROD_W-1:0] prod_d [LANES];

        always_comb begin
            prod_d = prod_q;
            if (capture) begin
                prod_d = prod;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                prod_q <= '{default: '0};
            end else begin
                prod_q <= prod_d;
            end
        end

        assign prod_use = prod_q;
    end else begin : g_comb
        logic unused_pipe;
        assign unused_pipe = ^{clk, reset, capture};
        assign prod_use    = prod;
    end

    // Adder tree: pairwise sums fit in 21 bits, final sum in 22
    logic signed [PAIR_W-1:0] sum01;
    logic signed [PAIR_W-1:0] sum23;

    assign sum01 = PAIR_W'(prod_use[0]) + PAIR_W'(prod_use[1]);
    assign sum23 = PAIR_W'(prod_use[2]) + PAIR_W'(prod_use[3]);
    assign dot   = DOT_W'(sum01) + DOT_W'(sum23);

endmodule
`default_nettype wire

// File: rtl/cfu_simd_mac_multi.sv
`default_nettype none
// ============================================================================
// Module   : cfu_simd_mac_multi
// Purpose  : Custom-function unit for int8 convolution / FC inner loops.
//            4-lane SIMD dot product with programmable offsets feeding a
//            bank of NUM_ACC accumulators, optional saturation. One
//            command in flight; the response is held until accepted.
// Ports    : clk, reset                - clock, sync active-high reset
//            cmd_valid / cmd_ready     - command handshake
//            cmd_payload_function_id   - [2:0] op, [9:3] funct7 (acc select)
//            cmd_payload_inputs_0/1    - packed activations/weights or operand
//            rsp_valid / rsp_ready     - response handshake
//            rsp_payload_outputs_0     - 32-bit result
// Revision : 1.0 - initial release
// ============================================================================
module cfu_simd_mac_multi
    import cfu_mac_pkg::*;
#(
    parameter int NUM_ACC  = 4,
    parameter int ACC_W    = 32,
    parameter int PIPE_MUL = 1,
    parameter int SATURATE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int SEL_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam int SUM_W = ACC_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [31:0]      rsp_q,     rsp_d;
    logic [OFF_W-1:0] in_off_q,  in_off_d;
    logic [OFF_W-1:0] flt_off_q, flt_off_d;
    logic [ACC_W-1:0] acc_q [NUM_ACC];
    logic [ACC_W-1:0] acc_d [NUM_ACC];

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic             accept;
    logic [2:0]       cmd_op;
    logic [SEL_W-1:0] cmd_sel;
    logic             unused_bits;

    assign accept      = cmd_valid && (state_q == IDLE);
    assign cmd_op      = cmd_payload_function_id[2:0];
    assign cmd_sel     = (NUM_ACC > 1) ? cmd_payload_function_id[3 +: SEL_W] : '0;
    assign unused_bits = ^cmd_payload_function_id[9:3+SEL_W];

    // Operands seen by the commit logic: the live command when the
    // result commits on the accept edge, otherwise a copy held over EXEC.
    logic [2:0]       x_op;
    logic [SEL_W-1:0] x_sel;
    logic [ACC_W-1:0] x_in0;
    logic [OFF_W-1:0] x_in1;
    logic             commit;

    if (PIPE_MUL != 0) begin : g_cmd_hold
        logic [2:0]       op_q,  op_d;
        logic [SEL_W-1:0] sel_q, sel_d;
        logic [ACC_W-1:0] in0_q, in0_d;
        logic [OFF_W-1:0] in1_q, in1_d;

        always_comb begin
            op_d  = op_q;
            sel_d = sel_q;
            in0_d = in0_q;
            in1_d = in1_q;
            if (accept) begin
                op_d  = cmd_op;
                sel_d = cmd_sel;
                in0_d = cmd_payload_inputs_0[ACC_W-1:0];
                in1_d = cmd_payload_inputs_1[OFF_W-1:0];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                op_q  <= '0;
                sel_q <= '0;
                in0_q <= '0;
                in1_q <= '0;
            end else begin
                op_q  <= op_d;
                sel_q <= sel_d;
                in0_q <= in0_d;
                in1_q <= in1_d;
            end
        end

        assign x_op   = op_q;
        assign x_sel  = sel_q;
        assign x_in0  = in0_q;
        assign x_in1  = in1_q;
        assign commit = (state_q == EXEC);
    end else begin : g_cmd_live
        assign x_op   = cmd_op;
        assign x_sel  = cmd_sel;
        assign x_in0  = cmd_payload_inputs_0[ACC_W-1:0];
        assign x_in1  = cmd_payload_inputs_1[OFF_W-1:0];
        assign commit = accept;
    end

    // ------------------------------------------------------------------
    // Dot product. Products are captured on the accept edge using the
    // offsets in force at that moment.
    // ------------------------------------------------------------------
    logic [DOT_W-1:0] dot;

    simd_dot4 #(
        .PIPE_MUL (PIPE_MUL)
    ) u_dot (
        .clk     (clk),
        .reset   (reset),
        .capture (accept),
        .in0     (cmd_payload_inputs_0),
        .in1     (cmd_payload_inputs_1),
        .in_off  (in_off_q),
        .flt_off (flt_off_q),
        .dot     (dot)
    );

    // ------------------------------------------------------------------
    // Accumulate with optional clamp. The sum is one bit wider than the
    // accumulator so overflow shows up as disagreement of the top bits.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]        acc_cur;
    logic signed [SUM_W-1:0] mac_sum;
    logic                    mac_ovf;
    logic [ACC_W-1:0]        mac_res;

    assign acc_cur = acc_q[x_sel];
    assign mac_sum = SUM_W'($signed(acc_cur)) + SUM_W'($signed(dot));
    assign mac_ovf = mac_sum[ACC_W] ^ mac_sum[ACC_W-1];

    always_comb begin
        mac_res = mac_sum[ACC_W-1:0];
        if ((SATURATE != 0) && mac_ovf) begin
            mac_res = mac_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    function automatic logic [31:0] to_rsp(input logic [ACC_W-1:0] v);
        return 32'($signed(v));
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rsp_d     = rsp_q;
        in_off_d  = in_off_q;
        flt_off_d = flt_off_q;
        acc_d     = acc_q;

        case (state_q)
            IDLE:    if (accept) state_d = (PIPE_MUL != 0) ? EXEC : RESP;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Commit coincides with the transition into RESP
        if (commit) begin
            rsp_d = '0;
            case (x_op)
                OP_MAC: begin
                    acc_d[x_sel] = mac_res;
                    rsp_d        = to_rsp(mac_res);
                end
                OP_SETOFF: begin
                    in_off_d  = x_in0[OFF_W-1:0];
                    flt_off_d = x_in1;
                end
                OP_LOAD: begin
                    acc_d[x_sel] = x_in0;
                    rsp_d        = to_rsp(acc_cur);
                end
                OP_READ: begin
                    rsp_d = to_rsp(acc_cur);
                end
                OP_CLRALL: begin
                    acc_d = '{default: '0};
                end
                default: begin
                    rsp_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rsp_q     <= '0;
            in_off_q  <= '0;
            flt_off_q <= '0;
            acc_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            rsp_q     <= rsp_d;
            in_off_q  <= in_off_d;
            flt_off_q <= flt_off_d;
            acc_q     <= acc_d;
        end
    end

    assign cmd_ready             = (state_q == IDLE);
    assign rsp_valid             = (state_q == RESP);
    assign rsp_payload_outputs_0 = rsp_q;

endmodule
`default_nettype wire

// File: tb/tb_cfu_simd_mac_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfu_simd_mac_multi
// Purpose  : Self-checking bench for cfu_simd_mac_multi. An arithmetic
//            model tracks accumulators and offsets; a monitor compares
//            every valid response with the model, and directed vectors
//            pin the model with hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfu_simd_mac_multi;

    localparam int NUM_ACC  = 4;
    localparam int ACC_W    = 32;
    localparam int PIPE_MUL = 1;
    localparam int SATURATE = 0;
    localparam int LAT      = (PIPE_MUL != 0) ? 2 : 1;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    cfu_simd_mac_multi #(
        .NUM_ACC  (NUM_ACC),
        .ACC_W    (ACC_W),
        .PIPE_MUL (PIPE_MUL),
        .SATURATE (SATURATE)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (plain integer arithmetic)
    // ------------------------------------------------------------------
    longint      m_acc [NUM_ACC];
    longint      m_in_off;
    longint      m_flt_off;
    logic [31:0] exp_rsp;

    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

    function automatic longint wrap(input longint s);
        longint m;
        m = s & ((longint'(1) <<< ACC_W) - 1);
        if (m > ACC_MAX) m = m - (longint'(1) <<< ACC_W);
        return m;
    endfunction

    function automatic longint dot_model(input logic [31:0] x, input logic [31:0] w);
        longint s;
        logic signed [7:0] xb;
        logic signed [7:0] wb;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            xb = x[8*i +: 8];
            wb = w[8*i +: 8];
            s += (longint'(xb) + m_in_off) * (longint'(wb) + m_flt_off);
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_ACC; i++) m_acc[i] = 0;
        m_in_off  = 0;
        m_flt_off = 0;
        exp_rsp   = 32'h0;
    endtask

    task automatic model_step(input logic [2:0] op, input int sel,
                              input logic [31:0] in0, input logic [31:0] in1);
        longint s;
        exp_rsp = 32'h0;
        case (op)
            3'd0: begin
                s = m_acc[sel] + dot_model(in0, in1);
                if (SATURATE != 0) s = (s > ACC_MAX) ? ACC_MAX : ((s < ACC_MIN) ? ACC_MIN : s);
                else               s = wrap(s);
                m_acc[sel] = s;
                exp_rsp    = 32'(s);
            end
            3'd1: begin
                m_in_off  = longint'($signed(in0[8:0]));
                m_flt_off = longint'($signed(in1[8:0]));
            end
            3'd2: begin
                exp_rsp    = 32'(m_acc[sel]);
                m_acc[sel] = wrap(longint'(in0));
            end
            3'd3: exp_rsp = 32'(m_acc[sel]);
            3'd4: for (int i = 0; i < NUM_ACC; i++) m_acc[i] = 0;
            default: exp_rsp = 32'h0;
        endcase
    endtask

    // ------------------------------------------------------------------
    // Monitor: every cycle a response is presented it must match the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            check("rsp_payload", rsp_payload_outputs_0, exp_rsp);
            check("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Issue one command at a negedge; returns the first response sample.
    // 'hold' keeps rsp_ready low for that many extra cycles; 'poke' offers
    // an extra MAC while the response is held.
    task automatic issue(input logic [2:0] op, input int sel,
                         input logic [31:0] in0, input logic [31:0] in1,
                         input int hold, input bit poke, output logic [31:0] resp);
        int lat;
        cmd_payload_function_id = {7'(sel), op};
        cmd_payload_inputs_0    = in0;
        cmd_payload_inputs_1    = in1;
        cmd_valid               = 1'b1;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        model_step(op, sel, in0, in1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(LAT));
        resp = rsp_payload_outputs_0;
        for (int c = 0; c < hold; c++) begin
            if (poke && c == 1) begin
                cmd_payload_function_id = {7'd0, 3'd0};
                cmd_payload_inputs_0    = 32'h01010101;
                cmd_payload_inputs_1    = 32'h01010101;
                cmd_valid               = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("held_valid",   32'(rsp_valid), 32'd1);
            check("held_payload", rsp_payload_outputs_0, resp);
            check("held_ready",   32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [31:0] r;

    initial begin
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0    = '0;
        cmd_payload_inputs_1    = '0;
        model_reset();
        do_reset();

        // Reset state
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_payload",   rsp_payload_outputs_0, 32'd0);

        // All accumulators read zero after reset
        for (int s = 0; s < 4; s++) begin
            issue(3'd3, s, 32'h0, 32'h0, 0, 1'b0, r);
            check("read_after_reset", r, 32'd0);
        end

        // Positive input offset: (4+128)+(3+128)+(2+128)+(1+128) = 522
        issue(3'd1, 0, 32'h00000080, 32'h0, 0, 1'b0, r);
        check("setoff_rsp", r, 32'd0);
        issue(3'd0, 1, 32'h01020304, 32'h01010101, 0, 1'b0, r);
        check("mac_offset", r, 32'd522);
        issue(3'd3, 0, 32'h0, 32'h0, 0, 1'b0, r);
        check("read_sel0_untouched", r, 32'd0);

        // Positive overflow: 0x7FFFFFF0 + 4*127*127
        issue(3'd2, 2, 32'h7FFFFFF0, 32'h0, 0, 1'b0, r);
        check("load_old", r, 32'd0);
        issue(3'd1, 0, 32'h0, 32'h0, 0, 1'b0, r);
        issue(3'd0, 2, 32'h7F7F7F7F, 32'h7F7F7F7F, 0, 1'b0, r);
        check("mac_pos_ovf", r, (SATURATE != 0) ? 32'h7FFFFFFF : 32'h8000FBF4);

        // Negative offsets: (-128-1)*(127-256) = 16641 per lane
        issue(3'd1, 0, 32'h000001FF, 32'h00000100, 0, 1'b0, r);
        issue(3'd0, 3, 32'h80808080, 32'h7F7F7F7F, 0, 1'b0, r);
        check("mac_neg_offsets", r, 32'h00010404);
        issue(3'd1, 0, 32'h0, 32'h0, 0, 1'b0, r);

        // Negative overflow: 0x80000010 + 4*(-128*127)
        issue(3'd2, 0, 32'h80000010, 32'h0, 0, 1'b0, r);
        issue(3'd0, 0, 32'h80808080, 32'h7F7F7F7F, 0, 1'b0, r);
        check("mac_neg_ovf", r, (SATURATE != 0) ? 32'h80000000 : 32'h7FFF0210);

        // Held response with an ignored command offered meanwhile
        issue(3'd3, 1, 32'h0, 32'h0, 5, 1'b1, r);
        check("held_read", r, 32'd522);
        issue(3'd3, 0, 32'h0, 32'h0, 0, 1'b0, r);
        check("poke_ignored", r, (SATURATE != 0) ? 32'h80000000 : 32'h7FFF0210);

        // Reset while the MAC is in flight: no response, nothing committed
        cmd_payload_function_id = {7'd3, 3'd0};
        cmd_payload_inputs_0    = 32'h01010101;
        cmd_payload_inputs_1    = 32'h01010101;
        cmd_valid               = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            check("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);
            check("rst_exec_ready",  32'(cmd_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        issue(3'd3, 3, 32'h0, 32'h0, 0, 1'b0, r);
        check("rst_exec_acc", r, 32'd0);

        // Reserved ops return zero and change nothing
        issue(3'd0, 2, 32'h01020304, 32'h01010101, 0, 1'b0, r);
        check("mac_plain", r, 32'd10);
        for (int op = 5; op < 8; op++) begin
            issue(3'(op), 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, r);
            check("reserved_op", r, 32'd0);
        end
        issue(3'd3, 2, 32'h0, 32'h0, 0, 1'b0, r);
        check("reserved_nochange", r, 32'd10);

        // MAC on every accumulator, then clear all
        for (int s = 0; s < 4; s++) issue(3'd0, s, 32'h05050505, 32'h02020202, 0, 1'b0, r);
        issue(3'd4, 0, 32'h0, 32'h0, 0, 1'b0, r);
        check("clrall_rsp", r, 32'd0);
        for (int s = 0; s < 4; s++) begin
            issue(3'd3, s, 32'h0, 32'h0, 0, 1'b0, r);
            check("read_after_clr", r, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cfu_simd_mac_multi.md
Name: cfu_simd_mac_multi

Overview:
- Parametrised successor CFU for int8 convolution/FC inner loops; sits on the CPU custom-instruction port (cmd/rsp handshake).
- 4-lane int8 SIMD dot-product with runtime-programmable input and filter offsets, NUM_ACC independent accumulators, optional multiply pipeline register and optional saturating accumulate.
- One command in flight; the response is held until the CPU accepts it.

Parameters:
- NUM_ACC, 4, number of accumulators; power of 2, 1..8.
- ACC_W, 32, accumulator width; 20..32; the response is sign-extended to 32 bits.
- PIPE_MUL, 1, 1 = register lane products (2-cycle latency); 0 = single-cycle.
- SATURATE, 0, 1 = MAC clamps to the signed ACC_W range; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command can be accepted
- cmd_payload_function_id  in  10  [2:0] = op; [9:3] = funct7, low log2(NUM_ACC) bits = acc select
- cmd_payload_inputs_0  in  32  four int8 activations, or operand
- cmd_payload_inputs_1  in  32  four int8 weights, or operand
- rsp_valid  out  1  response valid
- rsp_ready  in  1  CPU accepts response
- rsp_payload_outputs_0  out  32  result

Behaviour:
- Reset:
  - rsp_valid=0, rsp_payload_outputs_0=0, cmd_ready=1.
  - All accumulators=0; in_off=0, flt_off=0 (9-bit signed).
  - Pipeline valid cleared.
- Reset during a pending command or held response discards that command; no response is produced.
- Accept: cmd_valid & cmd_ready in the same cycle.
- cmd_ready=1 only in IDLE.
- States:
  - IDLE: on accept, go to EXEC if PIPE_MUL=1, else RESP.
  - EXEC: one cycle, products registered; go to RESP.
  - RESP: rsp_valid=1; output stable; leave to IDLE on rsp_ready.
- Latency: accept at cycle N gives rsp_valid at N+1 (PIPE_MUL=0) or N+2 (PIPE_MUL=1).
- rsp_ready is ignored outside RESP.
- Back-to-back: the cycle after the rsp handshake is IDLE, so the earliest next accept is one cycle after the response.
- Lane i (i=0..3) uses bits [8i+7:8i].
  - a_i = sext(in0 byte) + in_off; b_i = sext(in1 byte) + flt_off; both 10-bit signed.
  - p_i = a_i*b_i, 20-bit signed.
  - dot = p0+p1+p2+p3, 22-bit signed, sign-extended to ACC_W+1 before the add.
- Ops (sel = funct7 low bits):
  - 0 MAC: acc[sel] += dot, saturated or wrapped per SATURATE; response = new acc[sel].
  - 1 SETOFF: in_off=in0[8:0], flt_off=in1[8:0]; response 0.
  - 2 LOAD: acc[sel]=in0[ACC_W-1:0]; response = old acc[sel].
  - 3 READ: response = acc[sel]; no state change.
  - 4 CLRALL: all accs=0; response 0.
  - 5..7: no state change; response 0.
- State updates commit in the same cycle rsp_valid rises.
- An offset change applies to the next accepted command.
- Saturation: the clamp is computed on the (ACC_W+1)-bit sum; max = 2^(ACC_W-1)-1, min = -2^(ACC_W-1).

Decomposition:
- Package cfu_mac_pkg holds:
  - op codes OP_MAC..OP_CLRALL
  - lane count 4 and lane width 8
  - state enum IDLE/EXEC/RESP
- Sub-module simd_dot4: lane offset add, multiply, optional product register (PIPE_MUL), adder tree.
- The top holds the FSM, offset registers, accumulator bank and saturation.

Test Plan:
- Reset, then READ sel 0..3 -> all return 0; rsp_valid rises exactly 2 cycles after accept (PIPE_MUL=1).
- SETOFF in0=0x080, in1=0; MAC sel1 in0=0x01020304, in1=0x01010101 -> 522 (0x20A); READ sel0 -> 0.
- LOAD sel2 in0=0x7FFFFFF0; SETOFF 0,0; MAC sel2 in0=in1=0x7F7F7F7F -> 0x7FFFFFFF with SATURATE=1, 0x8000FBF4 with SATURATE=0.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and payload stable, cmd_ready=0, a cmd_valid pulse is ignored (no acc change); rsp_ready=1 -> next-cycle cmd_ready=1.
- Assert reset while in EXEC after a MAC -> no response, acc unchanged (0), cmd_ready=1 after reset.
- Op 6 with in0=0xFFFFFFFF -> response 0; CLRALL after MACs on all sels -> READs all 0.
